// File: rtl/mul_iter_pkg.sv
// Shared types and constants for the iterative multiplier.
package mul_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int unsigned MUL_CYCLES = 32;

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-add step: conditionally adds the shifted multiplicand magnitude.
module mul_step #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic [2*WIDTH-1:0] p,
    input  logic [WIDTH-1:0]   mag_a,
    input  logic               b_bit,
    input  logic [CNT_W-1:0]   cnt,
    output logic [2*WIDTH-1:0] p_next
);

    // Sum of magnitudes cannot exceed 2*WIDTH bits, so no carry out is lost.
    assign p_next = b_bit ? (p + ((2*WIDTH)'(mag_a) << cnt)) : p;

endmodule

// File: rtl/mul_iter.sv
// Iterative WIDTHxWIDTH multiplier: sign/magnitude capture, shift-add over WIDTH
// cycles, final negation, registered Busy/Valid/Result.
module mul_iter
    import mul_iter_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_CYCLES
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 Start,
    input  logic                 Signed,
    input  logic                 Flush,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 Busy,
    output logic                 Valid,
    output logic [2*WIDTH-1:0]   Result
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    mul_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg;
    logic [PW-1:0]    p;
    logic [PW-1:0]    p_next;
    logic             last_c;

    assign last_c = (cnt == CNT_W'(WIDTH - 1));

    mul_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .p      (p),
        .mag_a  (mag_a),
        .b_bit  (mag_b[cnt]),
        .cnt    (cnt),
        .p_next (p_next)
    );

    // FSM, operand capture and output registers; Flush outranks Start.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state  <= IDLE;
            cnt    <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            neg    <= 1'b0;
            p      <= '0;
            Busy   <= 1'b0;
            Valid  <= 1'b0;
            Result <= '0;
        end else begin
            Valid <= 1'b0;
            if (Flush) begin
                state <= IDLE;
                Busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (Start) begin
                            // |min negative| still fits as an unsigned magnitude.
                            mag_a <= (Signed && A[WIDTH-1]) ? -A : A;
                            mag_b <= (Signed && B[WIDTH-1]) ? -B : B;
                            neg   <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                            p     <= '0;
                            cnt   <= '0;
                            state <= BUSY;
                            Busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    BUSY: begin
                        p   <= p_next;
                        cnt <= cnt + CNT_W'(1);
                        if (last_c) begin
                            Result <= neg ? -p_next : p_next;
                            state  <= DONE;
                            Busy   <= 1'b0;
                            Valid  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Directed and randomized checks of mul_iter against an arithmetic product model.
module tb_mul_iter;

    logic        Clock;
    logic        nReset;
    logic        Start;
    logic        Signed;
    logic        Flush;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Valid;
    logic [63:0] Result;

    int checks   = 0;
    int failures = 0;

    mul_iter #(.WIDTH(32)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .Start  (Start),
        .Signed (Signed),
        .Flush  (Flush),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .Valid  (Valid),
        .Result (Result)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint prod;
        if (s) prod = longint'($signed(a)) * longint'($signed(b));
        else   prod = longint'({32'd0, a}) * longint'({32'd0, b});
        return 64'(prod);
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one operation and returns the number of edges from capture to Valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int n);
        A = a; B = b; Signed = s; Start = 1'b1;
        tick();
        Start = 1'b0;
        Signed = ~s;
        A = $urandom;
        B = $urandom;
        n = 1;
        while (!Valid && n < 60) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        logic [63:0] last_exp;
        logic [31:0] ra, rb;
        logic rs;
        logic saw_valid, saw_busy;

        nReset = 1'b0; Start = 1'b0; Signed = 1'b0; Flush = 1'b0; A = '0; B = '0;
        tick(); tick();
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_valid", 64'(Valid), 64'd0);
        chk("reset_result", Result, 64'd0);
        nReset = 1'b1;
        tick();

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, n);
        chk("umax_latency", 64'(n), 64'd33);
        chk("umax_result", Result, 64'hFFFF_FFFE_0000_0001);
        chk("umax_busy_low", 64'(Busy), 64'd0);
        tick();
        chk("valid_one_cycle", 64'(Valid), 64'd0);

        run_op(32'd7, 32'hFFFF_FFFD, 1'b1, n);
        chk("s7xm3_result", Result, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, n);
        chk("smin_sq_result", Result, 64'h4000_0000_0000_0000);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, n);
        chk("smin_x1_result", Result, 64'hFFFF_FFFF_8000_0000);
        last_exp = 64'hFFFF_FFFF_8000_0000;
        tick();

        // Flush on the tenth BUSY cycle together with a new Start.
        A = 32'd5; B = 32'd6; Signed = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (9) tick();
        Flush = 1'b1; Start = 1'b1; A = 32'd9; B = 32'd9;
        tick();
        Flush = 1'b0; Start = 1'b0;
        chk("flush_busy", 64'(Busy), 64'd0);
        chk("flush_valid", 64'(Valid), 64'd0);
        saw_valid = 1'b0; saw_busy = 1'b0;
        repeat (40) begin
            tick();
            saw_valid |= Valid;
            saw_busy  |= Busy;
        end
        chk("flush_no_valid", 64'(saw_valid), 64'd0);
        chk("flush_start_ignored", 64'(saw_busy), 64'd0);
        chk("flush_result_kept", Result, last_exp);

        // Flush sampled on the final iteration suppresses Valid.
        A = 32'd11; B = 32'd13; Signed = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (31) tick();
        chk("last_step_busy", 64'(Busy), 64'd1);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("last_flush_valid", 64'(Valid), 64'd0);
        chk("last_flush_busy", 64'(Busy), 64'd0);
        tick();
        chk("last_flush_valid2", 64'(Valid), 64'd0);
        chk("last_flush_result", Result, last_exp);

        // Start during BUSY is ignored; held Start in DONE chains a second op.
        A = 32'h9000_0000; B = 32'd3; Signed = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        n = 1;
        repeat (4) begin
            tick();
            n++;
        end
        A = 32'hFFFF_FFFB; B = 32'd1000; Signed = 1'b1; Start = 1'b1;
        while (!Valid && n < 60) begin
            tick();
            n++;
        end
        chk("b2b_first_latency", 64'(n), 64'd33);
        chk("b2b_first_result", Result, model(32'h9000_0000, 32'd3, 1'b0));
        n = 0;
        do begin
            tick();
            n++;
        end while (!Valid && n < 60);
        Start = 1'b0;
        chk("b2b_second_latency", 64'(n), 64'd33);
        chk("b2b_second_result", Result, 64'hFFFF_FFFF_FFFF_EC78);
        tick();

        // Asynchronous reset on the twentieth BUSY cycle.
        A = 32'd12345; B = 32'd678; Signed = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (19) tick();
        nReset = 1'b0;
        #1;
        chk("arst_busy", 64'(Busy), 64'd0);
        chk("arst_valid", 64'(Valid), 64'd0);
        chk("arst_result", Result, 64'd0);
        tick();
        nReset = 1'b1;
        tick();
        run_op(32'd12345, 32'd678, 1'b0, n);
        chk("post_rst_latency", 64'(n), 64'd33);
        chk("post_rst_result", Result, 64'd8369910);
        tick();

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i == 0) ra = 32'd0;
            if (i == 1) rb = 32'h7FFF_FFFF;
            if (i == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rs = 1'b1; end
            run_op(ra, rb, rs, n);
            chk($sformatf("rand%0d_latency", i), 64'(n), 64'd33);
            chk($sformatf("rand%0d_result", i), Result, model(ra, rb, rs));
            if (i % 4 == 0) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_iter.md
# mul_iter

Iterative 32×32 multiplier in the execute stage, directly upstream of the accumulator controller. Accepts MULT/MULTU/MADD/MADDU/MSUB/MSUBU operands from the ALU operand path and produces a 64-bit product over 32 cycles using radix-2 shift-add on operand magnitudes. The product is presented with a one-cycle `Valid` pulse and held stable for the accumulator's 64-bit `In` input. The pipeline controller stalls on `Busy`.

## Interface

Parameters:
- `WIDTH`, 32: operand width; product is 2×`WIDTH`.

Ports:
- `Clock`  in  1  single clock, rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request; sampled only in IDLE or DONE.
- `Signed`  in  1  1 means two's-complement operands (MULT/MADD/MSUB); 0 means unsigned.
- `Flush`  in  1  abort any operation in flight.
- `A`  in  32  multiplicand.
- `B`  in  32  multiplier.
- `Busy`  out  1  high in BUSY state.
- `Valid`  out  1  one-cycle pulse; `Result` is valid.
- `Result`  out  64  product; feeds the accumulator controller's `In`.

## Operation

- States:
  - IDLE: waiting for `Start`.
  - BUSY: 32 iteration steps, counter `Cnt` runs 0..31.
  - DONE: one cycle, `Valid`=1.
- Capture, on the edge with `Start`=1 in IDLE or DONE:
  - `MagA` = |A| and `MagB` = |B| when `Signed`=1; raw values otherwise.
  - `Neg` = `Signed` & (A[31]^B[31]).
  - Partial product register `P` = 0; `Cnt` = 0; state goes to BUSY.
- |0x80000000| = 0x80000000, which is representable as unsigned 32-bit. No special case.
- Each BUSY step:
  - If `MagB[Cnt]`, then `P` += `MagA` << `Cnt`, as a 64-bit add with no overflow possible.
  - `Cnt` increments.
- On the step with `Cnt`=31:
  - `Result` = `Neg` ? −P_final : P_final, in 64-bit two's complement.
  - State goes to DONE.
- DONE:
  - `Start`=1 captures new operands and returns to BUSY, giving back-to-back operations.
  - Otherwise the state goes to IDLE.
- `Result` holds its value until the next DONE entry. It is never cleared by `Flush`.
- `Flush`=1 forces IDLE from any state on the next edge.
  - `Valid` is suppressed if `Flush` is sampled in BUSY with `Cnt`=31.
  - `Flush` has priority over a simultaneous `Start`.
- `Start` while BUSY is ignored, with no queueing. The pipeline must hold operands until `Valid`.
- `Signed` is latched at capture. Later changes have no effect.

## Timing

- Reset values: state IDLE, `Busy`=0, `Valid`=0, `Result`=64'd0, `P`=0, `Cnt`=0.
- Reset assertion mid-operation aborts immediately and asynchronously. No `Valid` is produced.
- Latency, with capture edge E0:
  - Iteration edges E1..E32.
  - `Busy`=1 from after E0 through E32.
  - `Valid`=1 and `Result` valid in the cycle after E32.
  - Total: 33 cycles from `Start` to `Valid`.
- Back-to-back: `Start` held high during DONE gives `Valid` pulses every 33 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `Valid` is high for exactly one cycle per completed operation.

## Structure

- Add to `mul_definition.sv`:
  - state enum `mul_state_t` {IDLE, BUSY, DONE};
  - constant `MUL_CYCLES` = 32.
- Sub-module `mul_step`: combinational. Takes `P`, `MagA`, `MagB` bit, and `Cnt`; returns the next `P`. This lets the step be swapped for radix-4 Booth later without touching the FSM.
- The top level owns the FSM, operand/sign capture, final negation and the output registers.

## Test plan

- Unsigned 0xFFFFFFFF × 0xFFFFFFFF, `Signed`=0: `Valid` exactly 33 cycles after `Start`, `Result`=0xFFFFFFFE00000001.
- Signed 7 × 0xFFFFFFFD (−3): `Result`=0xFFFFFFFFFFFFFFEB.
- Signed edge operands:
  - 0x80000000 × 0x80000000 gives 0x4000000000000000.
  - 0x80000000 × 0x00000001 gives 0xFFFFFFFF80000000.
- `Flush` at cycle 10 of BUSY:
  - `Busy` drops next cycle, no `Valid` pulse, `Result` keeps its prior value.
  - A `Start` issued together with `Flush` is ignored.
- `Start` pulsed again during BUSY with new operands: ignored, and the original product is returned.
  - With `Start` held through DONE, a second `Valid` follows 33 cycles later with the second product.
- Drop `nReset` at cycle 20 of BUSY: all outputs zero immediately. After release, IDLE accepts a new `Start` normally.
